controller: RTL and testbench
=============================

Name: controller

Overview:
- Two-state Moore FSM that sequences the memory built-in self-test (MBIST) datapath.
- Idles in RESET, keeping the address counter loaded and the memory in normal mode.
- On `start`, enters TEST and drives the memory into test mode.
- Returns to RESET when the address counter signals terminal count (`cout`).

Parameters:
- None.

Ports:
- clk    input   1  system clock; all state updates on rising edge
- rst    input   1  asynchronous, active-high reset; forces state RESET immediately
- start  input   1  request to begin a test run; sampled on rising clk
- cout   input   1  counter terminal-count/carry-out; ends the test run; sampled on rising clk
- NbarT  output  1  mode select: 0 = normal operation, 1 = test mode
- ld     output  1  counter load enable: 1 = hold counter in load/initial state

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- State type:
  - Declared in package `controller_fsm_pkg` as enumerated type `state_t` with members RESET and TEST.
  - RESET is the first (encoding 0) member.
  - The state register is an internal signal named `state` of type `state_t`. Verification probes it hierarchically and prints it via `.name()`.
- Reset:
  - While `rst` is 1, `state` = RESET regardless of `clk`.
  - Entry into RESET takes effect on the `rst` rising edge, without waiting for a clock edge.
  - After `rst` deasserts, the FSM stays in RESET until a qualifying clock edge.
- Transitions, evaluated on each rising `clk` edge when `rst` = 0:
  - RESET, start = 1 -> TEST. `cout` is ignored in RESET, including when `start` and `cout` are both 1.
  - RESET, start = 0 -> RESET. This holds even if `cout` = 1.
  - TEST, cout = 1 -> RESET. `cout` has priority over `start`.
  - TEST, cout = 0 -> TEST. This holds even if `start` = 1; re-asserting `start` has no effect.
- Outputs are Moore, decoded combinationally from `state` only:
  - RESET: ld = 1, NbarT = 0.
  - TEST: ld = 0, NbarT = 1.
  - Outputs change only with `state`, i.e. on a rising clk edge or on `rst` assertion.
- Latency:
  - `start` or `cout` sampled at edge N produces the output change immediately after edge N.
  - A level held across one rising edge is sufficient.
- Reset mid-test: asserting `rst` in TEST returns the FSM to RESET asynchronously, giving ld = 1, NbarT = 0. It stays in RESET until `start` is sampled after `rst` deasserts.
- Unreachable or illegal encodings: the next state is RESET.
- No X-propagation onto outputs after reset.

Test Plan:
- Pulse rst = 1 with start = cout = 0 -> state RESET, ld = 1, NbarT = 0 before and after the next clk edge.
- Release rst, hold cout = 1, start = 0 across an edge -> remains RESET, ld = 1, NbarT = 0.
- start = 1 across one edge -> state TEST, ld = 0, NbarT = 1. Drop start, then re-assert start = 1 across another edge -> remains TEST, ld = 0, NbarT = 1.
- In TEST, cout = 1 across an edge -> RESET, ld = 1, NbarT = 0. Then start = 1 across an edge -> TEST again.
- In TEST, assert rst between clock edges:
  - Immediately before the asynchronous update settles, the FSM still reads TEST with ld = 0, NbarT = 1.
  - After the update (at the latest by the next edge) it reads RESET with ld = 1, NbarT = 0.
  - After releasing rst with start = 0, it stays RESET.
- Simultaneous start = 1 and cout = 1: in RESET -> TEST; in TEST -> RESET.

Source files
------------

// File: rtl/controller.sv
// MBIST sequencing controller: a two-state Moore FSM that holds the address
// counter in load while idle and switches the memory into test mode for the
// duration of one test run (start -> terminal count).

package controller_fsm_pkg;

  // RESET must stay the zero encoding so a cleared register means idle.
  typedef enum logic [0:0] {
    RESET = 1'b0,
    TEST  = 1'b1
  } state_t;

endpackage : controller_fsm_pkg

module controller
  import controller_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cout,
  output logic NbarT,
  output logic ld
);

  // The state register keeps the plain name "state" so it can be probed
  // hierarchically; its next-state value is state_d.
  state_t state;
  state_t state_d;

  // State register: asynchronous entry into RESET, otherwise follow state_d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      state <= state_d;
    end
  end

  // Next-state logic: start only matters when idle, cout only when testing.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = RESET;
    case (state)
      RESET: begin
        if (start) begin
          state_d = TEST;
        end else begin
          state_d = RESET;
        end
      end
      TEST: begin
        // Terminal count wins over a re-asserted start.
        if (cout) begin
          state_d = RESET;
        end else begin
          state_d = TEST;
        end
      end
      // Any encoding outside the enum falls back to idle.
      default: state_d = RESET;
    endcase
  end

  // Moore output decode: outputs depend on state alone.
  always_comb begin
    ld    = 1'b1;
    NbarT = 1'b0;
    case (state)
      RESET: begin
        ld    = 1'b1;
        NbarT = 1'b0;
      end
      TEST: begin
        ld    = 1'b0;
        NbarT = 1'b1;
      end
      default: begin
        ld    = 1'b1;
        NbarT = 1'b0;
      end
    endcase
  end

endmodule : controller

// File: tb/tb_controller.sv
// Self-checking bench for the MBIST controller: a table of per-edge
// vectors for the transition rules plus hand sequences for reset behaviour.

module tb_controller;
  import controller_fsm_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic cout;
  logic NbarT;
  logic ld;

  int n_checks = 0;
  int n_errors = 0;

  controller dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cout  (cout),
    .NbarT (NbarT),
    .ld    (ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    logic   start;
    logic   cout;
    state_t exp_state;
  } vec_t;

  // Expected outputs are derived from the expected state by the Moore table.
  task automatic check(input string name, input state_t exp_s);
    state_t act_s;
    logic   exp_ld;
    logic   exp_nb;
    act_s  = dut.state;
    exp_ld = (exp_s == RESET);
    exp_nb = (exp_s == TEST);
    n_checks++;
    if (act_s !== exp_s) begin
      n_errors++;
      $display("FAIL %s state: got %s want %s", name, act_s.name(), exp_s.name());
    end
    n_checks++;
    if (ld !== exp_ld) begin
      n_errors++;
      $display("FAIL %s ld: got %b want %b", name, ld, exp_ld);
    end
    n_checks++;
    if (NbarT !== exp_nb) begin
      n_errors++;
      $display("FAIL %s NbarT: got %b want %b", name, NbarT, exp_nb);
    end
  endtask

  // Drive inputs mid-cycle, let one rising edge sample them, check after it.
  task automatic step(input logic s, input logic c);
    @(negedge clk);
    start = s;
    cout  = c;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"idle_cout_ignored", 1'b0, 1'b1, RESET};
    vecs[1] = '{"start_enters_test", 1'b1, 1'b0, TEST};
    vecs[2] = '{"test_hold",         1'b0, 1'b0, TEST};
    vecs[3] = '{"restart_no_effect", 1'b1, 1'b0, TEST};
    vecs[4] = '{"cout_ends_test",    1'b0, 1'b1, RESET};
    vecs[5] = '{"both_in_reset",     1'b1, 1'b1, TEST};
    vecs[6] = '{"both_in_test",      1'b1, 1'b1, RESET};
    vecs[7] = '{"idle_hold",         1'b0, 1'b0, RESET};
    vecs[8] = '{"start_again",       1'b1, 1'b0, TEST};

    // Reset pulse before any clock edge, then across an edge.
    rst   = 1'b1;
    start = 1'b0;
    cout  = 1'b0;
    #2;
    check("reset_async", RESET);
    @(posedge clk);
    #1;
    check("reset_after_edge", RESET);
    @(negedge clk);
    rst = 1'b0;

    // Transition table, applied back to back from RESET.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].start, vecs[i].cout);
      check(vecs[i].name, vecs[i].exp_state);
    end

    // Asynchronous reset while in TEST (currently TEST after last vector).
    @(negedge clk);
    start = 1'b0;
    cout  = 1'b0;
    #1;
    check("pre_rst_in_test", TEST);
    rst = 1'b1;
    #1;
    check("rst_mid_test_async", RESET);
    @(posedge clk);
    #1;
    check("rst_held_edge", RESET);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0);
    check("post_rst_stay_idle", RESET);
    step(1'b1, 1'b0);
    check("post_rst_start", TEST);
    step(1'b0, 1'b1);
    check("final_cout", RESET);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_controller
